pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline hazard controller for the 4-stage CPU core (IF, ID, EX, MEM/WB). It sits beside the opcode decoder and produces the stall, bubble and flush controls for the PC and pipeline registers. It covers three cases: load-use hazards, taken branches resolved in EX, and the multi-cycle multiplier, which holds EX for `MUL_LAT` cycles. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- `REG_AW`, 4 — register index width.
- `MUL_LAT`, 3 — cycles a multiply occupies EX; legal range 1..15.
- `CNT_W`, 16 — width of the performance counters.

Ports:
- `i_clk` in 1 — single clock, rising edge.
- `i_rst_n` in 1 — reset, asynchronous, active-low.
- `i_id_valid` in 1 — ID stage holds a real instruction.
- `i_id_opcode` in 4 — ID-stage opcode.
- `i_id_rs1` in REG_AW — ID source register 1.
- `i_id_rs2` in REG_AW — ID source register 2.
- `i_id_immediate` in 1 — decoder immediate flag; when 1, rs2 is unused.
- `i_ex_regwrite` in 1 — EX instruction writes a register.
- `i_ex_memtoreg` in 1 — EX instruction is a load.
- `i_ex_rd` in REG_AW — EX destination register.
- `i_ex_branch_taken` in 1 — branch resolved taken in EX this cycle.
- `i_cnt_clr` in 1 — synchronous clear of both counters.
- `o_pc_stall` out 1 — hold PC.
- `o_ifid_stall` out 1 — hold IF/ID register.
- `o_ifid_flush` out 1 — clear IF/ID register to NOP.
- `o_idex_flush` out 1 — load a bubble into ID/EX.
- `o_ex_stall` out 1 — hold ID/EX register and the EX operands.
- `o_mul_busy` out 1 — multiplier sequencing in progress.
- `o_stall_cnt` out CNT_W — count of cycles with `o_pc_stall`=1, saturating.
- `o_flush_cnt` out CNT_W — count of taken-branch flush cycles, saturating.

## Operation
**Opcode classes**
- MUL: `0100`, `1000`.
- Branch: `1001`, `1010`. The taken outcome arrives only through `i_ex_branch_taken`.

**FSM states**
- `RUN` (2'd0): normal operation.
- `MUL_WAIT` (2'd1): multiplier holds EX.
- 4-bit down-counter `mul_cnt`.

**Hazard terms (combinational)**
- `lu_hit` = `i_id_valid` & `i_ex_memtoreg` & `i_ex_regwrite` & ((`i_ex_rd`==`i_id_rs1`) | (`i_ex_rd`==`i_id_rs2` & !`i_id_immediate`)).
  - All register indices compare, including index 0.
- `mul_issue` = state `RUN` & `i_id_valid` & opcode in MUL & !`i_ex_branch_taken` & !`lu_hit`.

**Priority in `RUN`**, highest first:
1. Taken branch: `o_ifid_flush`=1, `o_idex_flush`=1, no stall. `lu_hit` is ignored.
2. Load-use: `o_pc_stall`=1, `o_ifid_stall`=1, `o_idex_flush`=1. Exactly one bubble is inserted; the load then reaches MEM and forwarding covers it.
3. Otherwise all controls are 0.

**`MUL_WAIT`**
- `o_pc_stall`, `o_ifid_stall`, `o_ex_stall` and `o_mul_busy` are all 1; flush outputs are 0.
- `i_ex_branch_taken` and `lu_hit` are ignored, since EX holds the multiply.

**Transitions**
- `RUN` → `MUL_WAIT` on `mul_issue` when `MUL_LAT`>1; `mul_cnt` loads `MUL_LAT`-2.
- With `MUL_LAT`=1, the FSM never leaves `RUN`.
- In `MUL_WAIT`: if `mul_cnt`==0, go to `RUN`; otherwise decrement `mul_cnt`.
- Result: the multiply occupies EX for exactly `MUL_LAT` cycles, with `MUL_LAT`-1 stall cycles.

**Counters**
- `o_stall_cnt` increments on cycles with `o_pc_stall`=1; `o_flush_cnt` increments on cycles with `o_ifid_flush`=1.
- Both saturate at all-ones (no wrap).
- `i_cnt_clr` wins over increment in the same cycle.

## Timing
- **Reset:** asynchronous. State=`RUN`, `mul_cnt`=0, both counters 0. While `i_rst_n`=0, every control output is forced to 0 regardless of inputs.
- **Reset mid-multiply:** aborts immediately. The first cycle after release is `RUN` with all controls 0.
- **Control latency:** hazard outputs are combinational from inputs and state, valid in the same cycle. The pipeline registers act on them at the next rising edge.
- **State and counters:** update on the rising edge only.
- **Back-to-back multiplies:** the second MUL sits stalled in ID during `MUL_WAIT`. It issues in the first `RUN` cycle, unless a hazard of higher priority is present.
- **MUL in ID with `lu_hit`:** load-use stall first; the MUL issues the following cycle.
- **Branch taken while a MUL is in ID:** flush; the MUL is killed and never issues.

## Test plan
- **Load-use:** EX load rd=3, ID CAL_add rs1=3 → one cycle with `o_pc_stall`=`o_ifid_stall`=`o_idex_flush`=1, then 0; `o_stall_cnt`=1.
- **rs2 gating:** EX load rd=5, ID IMM_add rs2=5, `i_id_immediate`=1 → no stall. Repeat with CAL_sub → stall.
- **Branch flush:** `i_ex_branch_taken`=1 together with `lu_hit` → `o_ifid_flush`=`o_idex_flush`=1, `o_pc_stall`=0, `o_flush_cnt` increments.
- **Multiply with `MUL_LAT`=3:** CAL_mul issue → exactly 2 cycles of `o_ex_stall`=`o_mul_busy`=1, then `RUN`. A back-to-back IMM_mul gives another 2 stall cycles; `o_stall_cnt`=4.
- **Reset mid-multiply:** assert `i_rst_n`=0 during `MUL_WAIT` → outputs drop to 0 asynchronously; after release, state=`RUN` and counters=0.
- **Counter limits:** force `o_stall_cnt` to 16'hFFFF and continue stalling → holds 16'hFFFF. Assert `i_cnt_clr` during a stall → 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 4-stage core (IF, ID, EX, MEM/WB).
// Produces stall, bubble and flush controls for load-use hazards, taken
// branches resolved in EX, and the multi-cycle multiplier holding EX.
// Also keeps saturating stall and flush event counters for debug.
//
// state    | meaning
// ---------+---------------------------------------------------------
// RUN      | normal operation; branch flush / load-use bubble / issue
// MUL_WAIT | multiply holds EX; front end and EX operands are frozen
module pipeline_hazard_ctrl #(
  parameter int REG_AW  = 4,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [3:0]        i_id_opcode,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_immediate,
  input  logic              i_ex_regwrite,
  input  logic              i_ex_memtoreg,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_branch_taken,
  input  logic              i_cnt_clr,
  output logic              o_pc_stall,
  output logic              o_ifid_stall,
  output logic              o_ifid_flush,
  output logic              o_idex_flush,
  output logic              o_ex_stall,
  output logic              o_mul_busy,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1
  } state_t;

  // The first multiply cycle is the issue cycle in RUN, so the wait
  // counter covers the remaining MUL_LAT-1 cycles and exits at zero.
  localparam logic [3:0] MUL_LOAD = 4'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  state_t     state_q, state_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu_hit;
  logic is_mul;
  logic mul_issue;

  // Hazard detection terms from the current ID and EX contents
  always_comb begin
    lu_hit    = i_id_valid & i_ex_memtoreg & i_ex_regwrite &
                ((i_ex_rd == i_id_rs1) |
                 ((i_ex_rd == i_id_rs2) & ~i_id_immediate));
    is_mul    = (i_id_opcode == 4'b0100) | (i_id_opcode == 4'b1000);
    mul_issue = (state_q == RUN) & i_id_valid & is_mul &
                ~i_ex_branch_taken & ~lu_hit;
  end

  // Next-state and control outputs; everything is held low during reset
  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    o_pc_stall   = 1'b0;
    o_ifid_stall = 1'b0;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    o_ex_stall   = 1'b0;
    o_mul_busy   = 1'b0;
    if (i_rst_n) begin
      case (state_q)
        RUN: begin
          if (i_ex_branch_taken) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
          end else if (lu_hit) begin
            o_pc_stall   = 1'b1;
            o_ifid_stall = 1'b1;
            o_idex_flush = 1'b1;
          end else if (mul_issue && (MUL_LAT > 1)) begin
            state_d   = MUL_WAIT;
            mul_cnt_d = MUL_LOAD;
          end
        end
        MUL_WAIT: begin
          o_pc_stall   = 1'b1;
          o_ifid_stall = 1'b1;
          o_ex_stall   = 1'b1;
          o_mul_busy   = 1'b1;
          if (mul_cnt_q == 4'd0) begin
            state_d = RUN;
          end else begin
            mul_cnt_d = mul_cnt_q - 4'd1;
          end
        end
        default: begin
          state_d   = RUN;
          mul_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // Saturating event counters; clear takes precedence over counting
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (i_cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (o_pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (o_ifid_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  // State, multiply timer and counters registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= RUN;
      mul_cnt_q   <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW  = 4;
  localparam int MUL_LAT = 3;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic              id_valid;
  logic [3:0]        id_opcode;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_immediate;
  logic              ex_regwrite;
  logic              ex_memtoreg;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch_taken;
  logic              cnt_clr;
  logic              pc_stall;
  logic              ifid_stall;
  logic              ifid_flush;
  logic              idex_flush;
  logic              ex_stall;
  logic              mul_busy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  pipeline_hazard_ctrl #(
    .REG_AW (REG_AW),
    .MUL_LAT(MUL_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_id_valid       (id_valid),
    .i_id_opcode      (id_opcode),
    .i_id_rs1         (id_rs1),
    .i_id_rs2         (id_rs2),
    .i_id_immediate   (id_immediate),
    .i_ex_regwrite    (ex_regwrite),
    .i_ex_memtoreg    (ex_memtoreg),
    .i_ex_rd          (ex_rd),
    .i_ex_branch_taken(ex_branch_taken),
    .i_cnt_clr        (cnt_clr),
    .o_pc_stall       (pc_stall),
    .o_ifid_stall     (ifid_stall),
    .o_ifid_flush     (ifid_flush),
    .o_idex_flush     (idex_flush),
    .o_ex_stall       (ex_stall),
    .o_mul_busy       (mul_busy),
    .o_stall_cnt      (stall_cnt),
    .o_flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Model: number of remaining multiply stall cycles, plus plain counters
  int m_mul_left = 0;
  int m_stall    = 0;
  int m_flush    = 0;
  bit e_pc, e_ifid_st, e_ifid_fl, e_idex_fl, e_ex_st, e_busy;
  bit m_lu;

  function automatic void model_outputs();
    bit is_mul;
    m_lu = id_valid && ex_memtoreg && ex_regwrite &&
           ((ex_rd == id_rs1) || ((ex_rd == id_rs2) && !id_immediate));
    is_mul = (id_opcode == 4'd4) || (id_opcode == 4'd8);
    e_pc = 0; e_ifid_st = 0; e_ifid_fl = 0; e_idex_fl = 0; e_ex_st = 0; e_busy = 0;
    if (!rst_n) begin
      m_mul_left = 0; m_stall = 0; m_flush = 0;
    end else if (m_mul_left > 0) begin
      e_pc = 1; e_ifid_st = 1; e_ex_st = 1; e_busy = 1;
    end else if (ex_branch_taken) begin
      e_ifid_fl = 1; e_idex_fl = 1;
    end else if (m_lu) begin
      e_pc = 1; e_ifid_st = 1; e_idex_fl = 1;
    end
  endfunction

  function automatic void model_edge();
    bit is_mul;
    if (!rst_n) return;
    is_mul = (id_opcode == 4'd4) || (id_opcode == 4'd8);
    if (m_mul_left > 0) m_mul_left--;
    else if (id_valid && is_mul && !ex_branch_taken && !m_lu && MUL_LAT > 1)
      m_mul_left = MUL_LAT - 1;
    if (cnt_clr) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (e_pc && m_stall < CNT_MAX) m_stall++;
      if (e_ifid_fl && m_flush < CNT_MAX) m_flush++;
    end
  endfunction

  task automatic check_outputs();
    model_outputs();
    chk("pc_stall",   32'(pc_stall),   32'(e_pc));
    chk("ifid_stall", 32'(ifid_stall), 32'(e_ifid_st));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_ifid_fl));
    chk("idex_flush", 32'(idex_flush), 32'(e_idex_fl));
    chk("ex_stall",   32'(ex_stall),   32'(e_ex_st));
    chk("mul_busy",   32'(mul_busy),   32'(e_busy));
    chk("stall_cnt",  32'(stall_cnt),  32'(m_stall));
    chk("flush_cnt",  32'(flush_cnt),  32'(m_flush));
  endtask

  // One cycle: inputs were set at the falling edge; check, clock, advance model
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_opcode = 4'd0; id_rs1 = '0; id_rs2 = '0; id_immediate = 0;
    ex_regwrite = 0; ex_memtoreg = 0; ex_rd = '0; ex_branch_taken = 0; cnt_clr = 0;
  endtask

  task automatic set_load_ex(input logic [REG_AW-1:0] rd);
    ex_regwrite = 1; ex_memtoreg = 1; ex_rd = rd;
  endtask

  task automatic set_id(input logic [3:0] opc, input logic [REG_AW-1:0] r1,
                        input logic [REG_AW-1:0] r2, input logic imm);
    id_valid = 1; id_opcode = opc; id_rs1 = r1; id_rs2 = r2; id_immediate = imm;
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(negedge clk);
    // Reset with a live load-use pattern on the inputs: controls stay low
    set_load_ex(4'd3); set_id(4'd0, 4'd3, 4'd7, 0);
    step();
    chk("rst_pc_stall", 32'(pc_stall), 32'd0);
    rst_n = 1;
    idle();
    step();

    // Load-use on rs1: one bubble, then the bubble sits in EX
    set_load_ex(4'd3); set_id(4'd0, 4'd3, 4'd7, 0);
    #1 chk("lu_pc_stall", 32'(pc_stall), 32'd1);
    step();
    ex_regwrite = 0; ex_memtoreg = 0;
    step();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // rs2 only matters when the instruction is not immediate
    set_load_ex(4'd5); set_id(4'd0, 4'd1, 4'd5, 1);
    #1 chk("imm_no_stall", 32'(pc_stall), 32'd0);
    step();
    id_opcode = 4'd1; id_immediate = 0;
    #1 chk("rs2_stall", 32'(pc_stall), 32'd1);
    step();

    // Taken branch beats load-use
    set_load_ex(4'd2); set_id(4'd0, 4'd2, 4'd2, 0); ex_branch_taken = 1;
    #1 chk("br_no_stall", 32'(pc_stall), 32'd0);
    step();
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    idle();

    // Clear counters, then back-to-back multiplies
    cnt_clr = 1; step(); cnt_clr = 0;
    set_id(4'b0100, 4'd1, 4'd2, 0);
    step();
    set_id(4'b1000, 4'd3, 4'd0, 1);
    for (int i = 0; i < 2; i++) begin
      #1 chk("mul1_busy", 32'(mul_busy), 32'd1);
      step();
    end
    #1 chk("mul2_issue_busy", 32'(mul_busy), 32'd0);
    step();
    idle(); set_id(4'd0, 4'd0, 4'd0, 0);
    step(); step();
    #1 chk("mul_done_busy", 32'(mul_busy), 32'd0);
    chk("mul_stall_cnt", 32'(stall_cnt), 32'd4);
    step();

    // MUL behind a load-use waits one cycle, then issues
    set_load_ex(4'd6); set_id(4'b0100, 4'd6, 4'd0, 1);
    step();
    ex_regwrite = 0; ex_memtoreg = 0;
    step();
    idle();
    #1 chk("lu_then_mul_busy", 32'(mul_busy), 32'd1);
    step(); step(); step();

    // Branch kills a MUL sitting in ID
    set_id(4'b1000, 4'd1, 4'd1, 0); ex_branch_taken = 1;
    step();
    idle();
    #1 chk("br_kill_mul", 32'(mul_busy), 32'd0);
    step();

    // Asynchronous reset in the middle of a multiply
    set_id(4'b0100, 4'd1, 4'd2, 0);
    step();
    #1 chk("pre_rst_busy", 32'(mul_busy), 32'd1);
    rst_n = 0;
    #1 chk("async_rst_busy", 32'(mul_busy), 32'd0);
    chk("async_rst_stall", 32'(pc_stall), 32'd0);
    chk("async_rst_cnt", 32'(stall_cnt), 32'd0);
    step();
    rst_n = 1; idle();
    step();

    // Drive the stall counter into saturation with a persistent load-use
    set_load_ex(4'd9); set_id(4'd0, 4'd9, 4'd0, 1);
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      @(posedge clk);
      model_outputs();
      model_edge();
    end
    @(negedge clk);
    #1 chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    step();
    chk("stall_sat_hold", 32'(stall_cnt), 32'hFFFF);
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("clr_during_stall", 32'(stall_cnt), 32'd0);
    idle();

    // Random traffic with small register ranges so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      rst_n           = ($urandom_range(0, 499) != 0);
      id_valid        = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 3))
        0: id_opcode = 4'b0100;
        1: id_opcode = 4'b1000;
        default: id_opcode = 4'($urandom_range(0, 15));
      endcase
      id_rs1          = REG_AW'($urandom_range(0, 3));
      id_rs2          = REG_AW'($urandom_range(0, 3));
      id_immediate    = 1'($urandom_range(0, 1));
      ex_regwrite     = ($urandom_range(0, 3) != 0);
      ex_memtoreg     = 1'($urandom_range(0, 1));
      ex_rd           = REG_AW'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      cnt_clr         = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
